// File: rtl/pipe_operand_mux.sv
// Registered N-way operand selector feeding the ALU operand inputs.
// One pipeline stage with stall/flush, valid tracking, a sticky select error and a stall-length counter.
module pipe_operand_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 8,
    localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        data_out,
    output logic                    out_valid,
    output logic                    sel_err,
    output logic [CNT_W-1:0]        stall_cnt
);

    // One extra bit so NUM_IN itself is representable when it is a power of 2.
    localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W + 1)'(NUM_IN);

    logic             sel_ok;
    logic             load;
    logic             err_set;
    logic [WIDTH-1:0] sel_data;

    assign sel_ok  = ({1'b0, sel} < NUM_IN_EXT);
    assign load    = !flush && !stall;
    assign err_set = load && in_valid && !sel_ok;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            if (sel_ok) begin
                data_out  <= sel_data;
                out_valid <= in_valid;
            end else begin
                data_out  <= '0;
                out_valid <= 1'b0;
            end
        end
    end

    // Saturating count of consecutive stalled edges; any flush or load restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (flush || !stall) begin
            stall_cnt <= '0;
        end else if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Set takes precedence over a same-edge clear so no error event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (err_set) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_operand_mux.sv
// Directed bench for pipe_operand_mux: three instances cover the default
// configuration, a 2-bit saturating stall counter and a non-power-of-2 input count.
module tb_pipe_operand_mux;

    logic clk;
    logic rst;

    // Instance A: WIDTH=32, NUM_IN=4, CNT_W=8
    logic        a_stall, a_flush, a_in_valid, a_err_clr;
    logic [1:0]  a_sel;
    logic [127:0] a_data_in;
    logic [31:0] a_data_out;
    logic        a_out_valid, a_sel_err;
    logic [7:0]  a_stall_cnt;

    // Instance B: WIDTH=8, NUM_IN=4, CNT_W=2
    logic        b_stall, b_flush, b_in_valid, b_err_clr;
    logic [1:0]  b_sel;
    logic [31:0] b_data_in;
    logic [7:0]  b_data_out;
    logic        b_out_valid, b_sel_err;
    logic [1:0]  b_stall_cnt;

    // Instance C: WIDTH=8, NUM_IN=3, CNT_W=4
    logic        c_stall, c_flush, c_in_valid, c_err_clr;
    logic [1:0]  c_sel;
    logic [23:0] c_data_in;
    logic [7:0]  c_data_out;
    logic        c_out_valid, c_sel_err;
    logic [3:0]  c_stall_cnt;

    int n_cmp;
    int n_err;

    pipe_operand_mux #(.WIDTH(32), .NUM_IN(4), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .stall(a_stall), .flush(a_flush), .in_valid(a_in_valid),
        .sel(a_sel), .data_in(a_data_in), .err_clr(a_err_clr), .data_out(a_data_out),
        .out_valid(a_out_valid), .sel_err(a_sel_err), .stall_cnt(a_stall_cnt)
    );

    pipe_operand_mux #(.WIDTH(8), .NUM_IN(4), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .stall(b_stall), .flush(b_flush), .in_valid(b_in_valid),
        .sel(b_sel), .data_in(b_data_in), .err_clr(b_err_clr), .data_out(b_data_out),
        .out_valid(b_out_valid), .sel_err(b_sel_err), .stall_cnt(b_stall_cnt)
    );

    pipe_operand_mux #(.WIDTH(8), .NUM_IN(3), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .stall(c_stall), .flush(c_flush), .in_valid(c_in_valid),
        .sel(c_sel), .data_in(c_data_in), .err_clr(c_err_clr), .data_out(c_data_out),
        .out_valid(c_out_valid), .sel_err(c_sel_err), .stall_cnt(c_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        a_stall = 0; a_flush = 0; a_in_valid = 0; a_err_clr = 0; a_sel = 0; a_data_in = '0;
        b_stall = 0; b_flush = 0; b_in_valid = 0; b_err_clr = 0; b_sel = 0; b_data_in = '0;
        c_stall = 0; c_flush = 0; c_in_valid = 0; c_err_clr = 0; c_sel = 0; c_data_in = '0;

        #12;
        chk("rst_data",  32'(a_data_out), 32'h0);
        chk("rst_valid", 32'(a_out_valid), 0);
        chk("rst_err",   32'(a_sel_err), 0);
        chk("rst_cnt",   32'(a_stall_cnt), 0);

        @(negedge clk);
        rst = 1'b0;

        // Basic load: input 2 selected
        a_data_in  = {32'h44, 32'h33, 32'h22, 32'h11};
        a_sel      = 2'd2;
        a_in_valid = 1'b1;
        step();
        chk("load_data",  32'(a_data_out), 32'h33);
        chk("load_valid", 32'(a_out_valid), 1);
        chk("load_cnt",   32'(a_stall_cnt), 0);

        // Stall for three edges with a different select pending
        a_sel   = 2'd0;
        a_stall = 1'b1;
        step();
        chk("stall1_data", 32'(a_data_out), 32'h33);
        chk("stall1_cnt",  32'(a_stall_cnt), 1);
        step();
        chk("stall2_cnt",  32'(a_stall_cnt), 2);
        step();
        chk("stall3_data",  32'(a_data_out), 32'h33);
        chk("stall3_valid", 32'(a_out_valid), 1);
        chk("stall3_cnt",   32'(a_stall_cnt), 3);
        a_stall = 1'b0;
        step();
        chk("release_data", 32'(a_data_out), 32'h11);
        chk("release_cnt",  32'(a_stall_cnt), 0);

        // Flush wins over stall
        a_stall = 1'b1;
        step();
        chk("prefl_cnt", 32'(a_stall_cnt), 1);
        a_flush = 1'b1;
        step();
        chk("flush_data",  32'(a_data_out), 32'h0);
        chk("flush_valid", 32'(a_out_valid), 0);
        chk("flush_cnt",   32'(a_stall_cnt), 0);
        a_flush = 1'b0;
        a_stall = 1'b0;

        // Data captured even when in_valid=0
        a_sel      = 2'd1;
        a_in_valid = 1'b0;
        step();
        chk("inval_data",  32'(a_data_out), 32'h22);
        chk("inval_valid", 32'(a_out_valid), 0);

        // Load 0x44, then stall five edges to reach stall_cnt=5
        a_sel      = 2'd3;
        a_in_valid = 1'b1;
        step();
        chk("pre_rst_data", 32'(a_data_out), 32'h44);
        a_stall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("pre_rst_cnt",  32'(a_stall_cnt), 5);
        chk("pow2_no_err",  32'(a_sel_err), 0);

        // Asynchronous reset mid-cycle; check before the next rising edge
        #3;
        rst = 1'b1;
        #1;
        chk("async_data",  32'(a_data_out), 32'h0);
        chk("async_valid", 32'(a_out_valid), 0);
        chk("async_cnt",   32'(a_stall_cnt), 0);
        @(negedge clk);
        rst     = 1'b0;
        a_stall = 1'b0;
        step();
        chk("post_rst_data", 32'(a_data_out), 32'h44);

        // Instance B: 2-bit counter saturates at 3
        b_stall = 1'b1;
        step(); chk("sat1", 32'(b_stall_cnt), 1);
        step(); chk("sat2", 32'(b_stall_cnt), 2);
        step(); chk("sat3", 32'(b_stall_cnt), 3);
        step(); chk("sat4", 32'(b_stall_cnt), 3);
        step(); chk("sat5", 32'(b_stall_cnt), 3);
        b_stall = 1'b0;
        step(); chk("sat_clear", 32'(b_stall_cnt), 0);

        // Instance C: NUM_IN=3, out-of-range select
        c_data_in  = {8'hCC, 8'hBB, 8'hAA};
        c_sel      = 2'd1;
        c_in_valid = 1'b1;
        step();
        chk("c_load_data", 32'(c_data_out), 32'hBB);
        chk("c_load_err",  32'(c_sel_err), 0);
        c_sel = 2'd3;
        step();
        chk("c_oor_data",  32'(c_data_out), 32'h0);
        chk("c_oor_valid", 32'(c_out_valid), 0);
        chk("c_oor_err",   32'(c_sel_err), 1);
        c_err_clr = 1'b1;
        step();
        chk("c_set_wins", 32'(c_sel_err), 1);
        c_err_clr = 1'b0;
        c_flush   = 1'b1;
        c_sel     = 2'd2;
        step();
        chk("c_flush_err",   32'(c_sel_err), 1);
        chk("c_flush_valid", 32'(c_out_valid), 0);
        c_flush   = 1'b0;
        c_err_clr = 1'b1;
        c_sel     = 2'd0;
        step();
        chk("c_clr_err",  32'(c_sel_err), 0);
        chk("c_clr_data", 32'(c_data_out), 32'hAA);
        c_err_clr  = 1'b0;
        c_sel      = 2'd3;
        c_in_valid = 1'b0;
        step();
        chk("c_inval_oor_err",  32'(c_sel_err), 0);
        chk("c_inval_oor_data", 32'(c_data_out), 32'h0);
        c_in_valid = 1'b1;
        c_stall    = 1'b1;
        step();
        chk("c_stall_no_err", 32'(c_sel_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_operand_mux.md
Name: pipe_operand_mux

Overview:
- Parametrised, registered N-way operand selector for the pipelined datapath.
- Generalises the fixed-width 2:1 selectors to any width and input count.
- Adds a pipeline-register stage with stall (hold), flush (bubble insertion), valid tracking, an out-of-range select error flag and a stall-length counter.
- Sits between the hazard/forwarding unit and the ALU operand inputs. It replaces a separate forwarding mux plus pipeline register.

Parameters:
- WIDTH, 32: data width per input and of data_out.
- NUM_IN, 4: number of selectable inputs, at least 2.
- CNT_W, 8: width of the stall counter.
- Derived localparam SEL_W = max(1, clog2(NUM_IN)).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the current output register.
- flush  in  1  insert a bubble: clear valid and data.
- in_valid  in  1  the selected operand is valid this cycle.
- sel  in  SEL_W  binary select; input k occupies bits data_in[k*WIDTH +: WIDTH].
- data_in  in  NUM_IN*WIDTH  flattened candidate operands.
- err_clr  in  1  clear the sticky select error.
- data_out  out  WIDTH  registered selected operand.
- out_valid  out  1  data_out holds a valid operand.
- sel_err  out  1  sticky flag: a valid select was out of range.
- stall_cnt  out  CNT_W  count of consecutive stall cycles, saturating.

Behaviour:
- Reset:
  - rst is asynchronous and active-high. Asserting it immediately forces data_out=0, out_valid=0, sel_err=0, stall_cnt=0.
  - Reset asserted mid-operation discards any held operand.
  - The first capture happens at the first rising edge after rst deasserts.
- Latency: 1 cycle. Inputs sampled at edge t appear on the outputs after edge t. There is no combinational path from input to output.
- Per-edge priority is flush > stall > load:
  - flush=1: data_out<=0, out_valid<=0. This applies even if stall=1. stall_cnt<=0.
  - flush=0, stall=1: data_out and out_valid hold. stall_cnt<=stall_cnt+1, saturating at 2^CNT_W-1 with no wrap.
  - flush=0, stall=0 (load): stall_cnt<=0. Then:
    - If sel<NUM_IN: data_out<=data_in slice sel, out_valid<=in_valid.
    - If sel>=NUM_IN (possible only when NUM_IN is not a power of 2): data_out<=0, out_valid<=0.
  - Data is captured even when in_valid=0, but out_valid tracks in_valid.
- sel_err:
  - Set on a load cycle when in_valid=1 and sel>=NUM_IN.
  - Cleared on an edge with err_clr=1.
  - If set and clear occur on the same edge, set wins.
  - Unaffected by stall and flush.
  - Remains 0 forever when NUM_IN is a power of 2.
- No internal state other than the four output registers.

Test Plan:
- NUM_IN=4, WIDTH=32. Reset, then set inputs {0x11,0x22,0x33,0x44}, sel=2, in_valid=1 → one edge later data_out=0x33, out_valid=1, stall_cnt=0.
- Load 0x33, then stall=1 for 3 edges while sel=0 → data_out stays 0x33 and stall_cnt=1,2,3. Release stall → data_out=0x11 and stall_cnt=0.
- Assert flush with stall on the same edge → data_out=0, out_valid=0, stall_cnt=0.
- CNT_W=2, stall held for 5 edges → stall_cnt sequence 1,2,3,3,3, with no wrap.
- NUM_IN=3 (SEL_W=2), sel=3, in_valid=1 → data_out=0, out_valid=0, sel_err=1. Then err_clr=1 together with another sel=3 valid load → sel_err stays 1. Then err_clr=1 alone → sel_err=0.
- Assert rst asynchronously mid-cycle while data_out=0x44 and stall_cnt=5 → outputs go to 0 before the next clock edge.
